// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bus: pipeline control, ID-stage control-flow info, predictor
// results in; fetch address, redirect and performance counters out.
interface fetch_pc_unit_if #(
  parameter int unsigned PERF_CNT_WIDTH = 32
);
  logic                      PL_stall;
  logic                      PL_flush;
  logic [31:0]               ex_redirect_pc;
  logic                      B_type_id;
  logic                      jal_id;
  logic                      jalr_id;
  logic [31:0]               pc_id;
  logic [31:0]               imme_id;
  logic                      B_type_prediction_result;
  logic [31:0]               jalr_prediction_result;
  logic [31:0]               pc;
  logic [31:0]               pc_add_4;
  logic                      id_redirect;
  logic                      pred_taken_ex;
  logic [PERF_CNT_WIDTH-1:0] branch_cnt;
  logic [PERF_CNT_WIDTH-1:0] mispredict_cnt;

  // Pipeline/predictor side.
  modport master (
    output PL_stall, PL_flush, ex_redirect_pc, B_type_id, jal_id, jalr_id,
           pc_id, imme_id, B_type_prediction_result, jalr_prediction_result,
    input  pc, pc_add_4, id_redirect, pred_taken_ex, branch_cnt, mispredict_cnt
  );

  // Fetch PC unit side.
  modport slave (
    input  PL_stall, PL_flush, ex_redirect_pc, B_type_id, jal_id, jalr_id,
           pc_id, imme_id, B_type_prediction_result, jalr_prediction_result,
    output pc, pc_add_4, id_redirect, pred_taken_ex, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: selects the next fetch address from reset, EX flush, stall,
// ID-stage predicted redirect or sequential fetch, and keeps branch and
// misprediction counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned PERF_CNT_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  fetch_pc_unit_if.slave bus
);

  // BOOT/RECOVER mean ID holds a bubble, so its control-flow bits are ignored.
  typedef enum logic [1:0] {StBoot, StRun, StRecover} state_e;

  state_e                    state_q, state_d;
  logic [31:0]               pc_q, pc_d;
  logic [31:0]               id_target;
  logic                      pred_q, pred_d;
  logic [PERF_CNT_WIDTH-1:0] branch_cnt_q, mispredict_cnt_q;
  logic                      id_valid;
  logic                      id_redirect;
  logic                      branch_seen;

  assign id_valid    = (state_q == StRun);
  assign id_redirect = id_valid && !bus.PL_stall && !bus.PL_flush &&
                       (bus.jal_id || bus.jalr_id ||
                        (bus.B_type_id && bus.B_type_prediction_result));
  assign branch_seen = id_valid && bus.B_type_id && !bus.PL_stall && !bus.PL_flush;

  // jalr target comes from the return stack with bit 0 cleared; jal and taken
  // branches are PC-relative.
  assign id_target = bus.jalr_id ? {bus.jalr_prediction_result[31:1], 1'b0}
                                 : bus.pc_id + bus.imme_id;

  // Next fetch address and staged prediction; flush beats stall.
  always_comb begin
    pc_d   = pc_q + 32'd4;
    pred_d = pred_q;
    if (bus.PL_flush) begin
      pc_d   = bus.ex_redirect_pc;
      pred_d = 1'b0;
    end else if (bus.PL_stall) begin
      pc_d   = pc_q;
    end else begin
      pred_d = id_valid && bus.B_type_id && bus.B_type_prediction_result;
      if (id_redirect) begin
        pc_d = id_target;
      end
    end
  end

  // Next FSM state.
  always_comb begin
    state_d = state_q;
    if (bus.PL_flush) begin
      state_d = StRecover;
    end else if (state_q == StRun) begin
      if (id_redirect) begin
        state_d = StRecover;
      end
    end else if (!bus.PL_stall) begin
      state_d = StRun;
    end
  end

  // State, fetch PC, staged prediction and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StBoot;
      pc_q             <= RESET_PC;
      pred_q           <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pred_q  <= pred_d;
      if (branch_seen && (branch_cnt_q != '1)) begin
        branch_cnt_q <= branch_cnt_q + 1'b1;
      end
      if (bus.PL_flush && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
      end
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_add_4       = pc_q + 32'd4;
  assign bus.id_redirect    = id_redirect;
  assign bus.pred_taken_ex  = pred_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule
